// File: rtl/env_vca.sv
// Envelope-controlled amplifier: scales a signed sample by an 8-bit ADSR envelope
// using a 9-cycle serial shift-add multiplier behind a valid/ready handshake.
module env_vca #(
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [7:0]          envelope,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                busy
);

  localparam int ACC_W = SAMPLE_W + 9;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          r_state;
  logic [SAMPLE_W-1:0] r_sample;
  logic [8:0]          r_gain;
  logic [3:0]          r_bit;
  logic [ACC_W-1:0]    r_acc;
  logic [SAMPLE_W-1:0] r_sample_out;

  logic [8:0]          w_gain;
  logic [ACC_W-1:0]    w_sext;
  logic [ACC_W-1:0]    w_addend;
  logic [ACC_W-1:0]    w_acc_next;
  logic                w_last;

  // envelope+1 makes 255 an exact unity gain while 0 stays fully silent.
  assign w_gain     = (envelope == 8'd0) ? 9'd0 : ({1'b0, envelope} + 9'd1);
  assign w_sext     = {{9{r_sample[SAMPLE_W-1]}}, r_sample};
  assign w_addend   = r_gain[r_bit] ? (w_sext << r_bit) : '0;
  assign w_acc_next = r_acc + w_addend;
  assign w_last     = (r_bit == 4'd8);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sample     <= '0;
      r_gain       <= '0;
      r_bit        <= '0;
      r_acc        <= '0;
      r_sample_out <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sample <= sample_in;
            r_gain   <= w_gain;
            r_acc    <= '0;
            r_bit    <= '0;
            r_state  <= S_MUL;
          end
        end
        S_MUL: begin
          r_acc <= w_acc_next;
          if (w_last) begin
            // Load on the last partial product so the result is visible during DONE.
            r_sample_out <= w_acc_next[SAMPLE_W+7:8];
            r_state      <= S_DONE;
          end else begin
            r_bit <= r_bit + 4'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE) & ~rst;
  assign out_valid  = (r_state == S_DONE) & ~rst;
  assign busy       = (r_state != S_IDLE);
  assign sample_out = r_sample_out;

endmodule

// File: tb/tb_env_vca.sv
// Directed bench for env_vca: table of single-sample vectors plus hand-written
// back-to-back, ignored-input and reset-abort sequences.
module tb_env_vca;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] sample_in = '0;
  logic [7:0]   envelope = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sample_out;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  env_vca #(.SAMPLE_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sample_in  (sample_in),
    .envelope   (envelope),
    .out_valid  (out_valid),
    .sample_out (sample_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0] s;
    logic [7:0]        env;
    logic signed [7:0] exp;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Single accept, then watch 12 cycles: latency, one pulse, value, ready/busy shape.
  task automatic run_one(input logic signed [7:0] s, input logic [7:0] env,
                         input logic signed [7:0] exp, input string tag);
    int lat;
    int pulses;
    int ready_hi;
    int val;
    int busy1;
    int busy11;
    int ready11;
    @(negedge clk);
    check({tag, " ready_before"}, longint'(in_ready), 1);
    in_valid  = 1'b1;
    sample_in = s;
    envelope  = env;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    sample_in = ~s;
    envelope  = 8'd0;
    lat = -1; pulses = 0; ready_hi = 0; val = 0;
    busy1 = 0; busy11 = 1; ready11 = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (out_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          val = int'($signed(sample_out));
        end
      end
      if (n <= 10 && in_ready) ready_hi++;
      if (n == 1) busy1 = int'(busy);
      if (n == 11) begin
        busy11  = int'(busy);
        ready11 = int'(in_ready);
      end
      if (n == 12) check({tag, " hold"}, longint'($signed(sample_out)), longint'(exp));
    end
    check({tag, " latency"}, lat, 10);
    check({tag, " pulses"}, pulses, 1);
    check({tag, " value"}, val, longint'(exp));
    check({tag, " ready_low_busy"}, ready_hi, 0);
    check({tag, " ready_after"}, ready11, 1);
    check({tag, " busy_mul"}, busy1, 1);
    check({tag, " busy_idle"}, busy11, 0);
  endtask

  initial begin
    vec_t   vecs [11];
    longint acc_mask;
    longint ov_mask;
    int     vals [4];
    int     nv;
    int     pulses;
    int     val;
    int     lat;
    int     busy_hi;

    vecs[0]  = '{s:  8'sd100, env: 8'd255, exp:  8'sd100};
    vecs[1]  = '{s: -8'sd128, env: 8'd0,   exp:  8'sd0};
    vecs[2]  = '{s:  8'sd127, env: 8'd128, exp:  8'sd63};
    vecs[3]  = '{s: -8'sd100, env: 8'd64,  exp: -8'sd26};
    vecs[4]  = '{s: -8'sd1,   env: 8'd1,   exp: -8'sd1};
    vecs[5]  = '{s: -8'sd128, env: 8'd255, exp: -8'sd128};
    vecs[6]  = '{s:  8'sd127, env: 8'd255, exp:  8'sd127};
    vecs[7]  = '{s:  8'sd1,   env: 8'd254, exp:  8'sd0};
    vecs[8]  = '{s:  8'sd64,  env: 8'd127, exp:  8'sd32};
    vecs[9]  = '{s: -8'sd7,   env: 8'd200, exp: -8'sd6};
    vecs[10] = '{s:  8'sd5,   env: 8'd0,   exp:  8'sd0};

    // Reset with in_valid high: reset must win.
    rst = 1'b1; in_valid = 1'b1; sample_in = 8'h55; envelope = 8'd255;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", longint'(in_ready), 0);
    check("rst out_valid", longint'(out_valid), 0);
    check("rst busy", longint'(busy), 0);
    check("rst sample_out", longint'(sample_out), 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst in_ready", longint'(in_ready), 1);
    @(negedge clk);
    check("post_rst busy", longint'(busy), 0);

    for (int i = 0; i < 11; i++)
      run_one(vecs[i].s, vecs[i].env, vecs[i].exp, $sformatf("vec%0d", i));

    // Back-to-back with in_valid held; envelope zeroed during the first MUL window.
    acc_mask = 0; ov_mask = 0; nv = 0;
    for (int c = 0; c <= 36; c++) begin
      @(negedge clk);
      if (out_valid) begin
        ov_mask[c] = 1'b1;
        if (nv < 4) vals[nv] = int'($signed(sample_out));
        nv++;
      end
      if (c < 11) begin
        sample_in = 8'sd90;
        envelope  = (c >= 1 && c <= 9) ? 8'd0 : 8'd255;
      end else if (c < 22) begin
        sample_in = -8'sd50; envelope = 8'd128;
      end else begin
        sample_in = 8'sd33;  envelope = 8'd16;
      end
      in_valid = (c < 33);
      #1;
      if (in_valid && in_ready) acc_mask[c] = 1'b1;
    end
    in_valid = 1'b0;
    check("b2b accepts", acc_mask, (64'd1 << 0) | (64'd1 << 11) | (64'd1 << 22));
    check("b2b out_valids", ov_mask, (64'd1 << 10) | (64'd1 << 21) | (64'd1 << 32));
    check("b2b count", nv, 3);
    check("b2b val0", vals[0], 90);
    check("b2b val1", vals[1], -26);
    check("b2b val2", vals[2], 2);

    // in_valid pulsed during MUL must be ignored.
    @(negedge clk);
    check("ign ready_before", longint'(in_ready), 1);
    in_valid = 1'b1; sample_in = 8'sd40; envelope = 8'd255;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pulses = 0; val = 0; lat = -1; busy_hi = 0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (out_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          val = int'($signed(sample_out));
        end
      end
      if (n >= 12 && busy) busy_hi++;
      if (n == 4) begin
        in_valid = 1'b1; sample_in = -8'sd99; envelope = 8'd200;
      end else begin
        in_valid = 1'b0;
      end
    end
    check("ign pulses", pulses, 1);
    check("ign latency", lat, 10);
    check("ign value", val, 40);
    check("ign no_extra_busy", busy_hi, 0);

    // Reset during MUL aborts the sample and clears sample_out.
    @(negedge clk);
    check("rmid ready_before", longint'(in_ready), 1);
    in_valid = 1'b1; sample_in = 8'sd77; envelope = 8'd255;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    rst = 1'b1;
    #1;
    check("rmid in_ready_in_rst", longint'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rmid in_ready_after", longint'(in_ready), 1);
    check("rmid sample_out", longint'(sample_out), 0);
    check("rmid busy", longint'(busy), 0);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("rmid no_pulse", pulses, 0);
    run_one(8'sd50, 8'd255, 8'sd50, "rmid next");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
